ram_dp_param: RTL and testbench

//  Parametrised simple-dual-port synchronous RAM: one write port and one read port, usable in the same cycle.

---
 rtl/ram_dp_param_pkg.sv | 16 +
 rtl/ram_dp_param_if.sv | 26 ++
 rtl/ram_core_array.sv | 23 ++
 rtl/ram_dp_param.sv | 146 ++++++++++++++
 tb/tb_ram_dp_param.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_dp_param_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package ram_dp_param_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// Request/response bundle of the dual-port RAM; master drives requests, slave is the RAM.
interface ram_dp_param_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
);
  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ready;
  logic              busy_drop;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, ready, busy_drop
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, ready, busy_drop
  );
endinterface

// File: rtl/ram_core_array.sv
// Reset-free storage: one write port and one registered read port, block-RAM inferable.
module ram_core_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read samples the pre-write content on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with post-reset init sweep, ready/valid, selectable latency and collision policy.
module ram_dp_param
  import ram_dp_param_pkg::*;
#(
  parameter int unsigned        DATA_W   = 4,
  parameter int unsigned        ADDR_W   = 2,
  parameter int unsigned        RD_LAT   = 1,
  parameter int unsigned        WR_FIRST = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_dp_param_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          LAT2  = rd_lat_legal(RD_LAT) && (RD_LAT == RD_LAT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic              wr_go, rd_go, byp_hit;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata, s1_data;
  logic              v1_q, byp_q;
  logic [DATA_W-1:0] byp_data_q;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: sweep DEPTH words, then serve requests until clr.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (bus.clr) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
    busy_d  = (bus.wr_en | bus.rd_en) & ~ready_q;
  end

  // A read that coincides with clr is discarded so rd_data is left untouched.
  assign wr_go   = ready_q & bus.wr_en;
  assign rd_go   = ready_q & bus.rd_en & ~bus.clr;
  assign byp_hit = (WR_FIRST != 0) && wr_go && rd_go && (bus.wr_addr == bus.rd_addr);

  assign arr_we    = (state_q == ST_INIT) | wr_go;
  assign arr_waddr = (state_q == ST_INIT) ? cnt_q[ADDR_W-1:0] : bus.wr_addr;
  assign arr_wdata = (state_q == ST_INIT) ? INIT_VAL : bus.wr_data;

  ram_core_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_go),
    .raddr (bus.rd_addr),
    .rdata (arr_rdata)
  );

  // First read stage: valid flag and write-first bypass capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      v1_q <= rd_go;
      if (rd_go) begin
        byp_q      <= byp_hit;
        byp_data_q <= bus.wr_data;
      end
    end
  end

  assign s1_data = byp_q ? byp_data_q : arr_rdata;

  if (LAT2) begin : gen_lat2
    logic              v2_q;
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        rd_q <= '0;
      end else begin
        v2_q <= v1_q & ~bus.clr;
        if (v1_q & ~bus.clr) rd_q <= s1_data;
      end
    end

    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = v2_q;
  end else begin : gen_lat1
    // The array read register has no reset, so mask it until the first read lands.
    logic have_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     have_q <= 1'b0;
      else if (rd_go) have_q <= 1'b1;
    end

    assign bus.rd_data  = have_q ? s1_data : '0;
    assign bus.rd_valid = v1_q;
  end

  assign bus.ready     = ready_q;
  assign bus.busy_drop = busy_q;
endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: three configurations driven by directed vectors.
module tb_ram_dp_param;
  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_n_c;
  int   cyc_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  ram_dp_param_if #(.DATA_W(4), .ADDR_W(2)) ifa ();
  ram_dp_param_if #(.DATA_W(4), .ADDR_W(2)) ifb ();
  ram_dp_param_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

  ram_dp_param #(.DATA_W(4), .ADDR_W(2), .RD_LAT(1), .WR_FIRST(1), .INIT_VAL(4'h0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ram_dp_param #(.DATA_W(4), .ADDR_W(2), .RD_LAT(2), .WR_FIRST(0), .INIT_VAL(4'h0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  ram_dp_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .WR_FIRST(1), .INIT_VAL(8'hA5))
    u_c (.clk(clk), .rst_n(rst_n_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic sb_cmp(input string nm, input bit none, input exp_t e, input logic [7:0] act,
                        input int lat);
    vectors++;
    if (none) begin
      miscompares++;
      $display("FAIL %s: unexpected rd_valid with rd_data=%h, no read outstanding", nm, act);
    end else if (act !== e.d || (cyc_n - e.c) != lat) begin
      miscompares++;
      $display("FAIL %s: got %h after %0d cycles, required %h after %0d cycles",
               nm, act, cyc_n - e.c, e.d, lat);
    end
  endtask

  // Monitors: every rd_valid pulse consumes one expectation.
  always @(negedge clk) if (ifa.rd_valid === 1'b1) begin
    if (qa.size() == 0) sb_cmp("sb_a", 1'b1, exp_t'{d: 8'h00, c: 0}, 8'(ifa.rd_data), 1);
    else                sb_cmp("sb_a", 1'b0, qa.pop_front(), 8'(ifa.rd_data), 1);
  end
  always @(negedge clk) if (ifb.rd_valid === 1'b1) begin
    if (qb.size() == 0) sb_cmp("sb_b", 1'b1, exp_t'{d: 8'h00, c: 0}, 8'(ifb.rd_data), 2);
    else                sb_cmp("sb_b", 1'b0, qb.pop_front(), 8'(ifb.rd_data), 2);
  end
  always @(negedge clk) if (ifc.rd_valid === 1'b1) begin
    if (qc.size() == 0) sb_cmp("sb_c", 1'b1, exp_t'{d: 8'h00, c: 0}, ifc.rd_data, 1);
    else                sb_cmp("sb_c", 1'b0, qc.pop_front(), ifc.rd_data, 1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the two small RAMs; sc[0]/sc[1] say whether A/B must deliver this read.
  task automatic op(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                    input logic re, input logic [1:0] ra, input logic [3:0] ea,
                    input logic [3:0] eb, input logic [1:0] sc);
    ifa.clr = 1'b0;  ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd;
    ifa.rd_en = re;  ifa.rd_addr = ra;
    ifb.clr = 1'b0;  ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd;
    ifb.rd_en = re;  ifb.rd_addr = ra;
    if (re && sc[0]) qa.push_back(exp_t'{d: 8'(ea), c: cyc_n});
    if (re && sc[1]) qb.push_back(exp_t'{d: 8'(eb), c: cyc_n});
    cyc();
  endtask

  task automatic idle(input int n);
    ifa.clr = 1'b0; ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    ifb.clr = 1'b0; ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic set_clr(input logic v);
    ifa.clr = v;
    ifb.clr = v;
  endtask

  task automatic chk_ready(input string nm, input logic exp);
    chk({nm, "_a"}, 8'(ifa.ready), 8'(exp));
    chk({nm, "_b"}, 8'(ifb.ready), 8'(exp));
  endtask

  task automatic opc(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                     input logic re, input logic [3:0] ra, input logic [7:0] ec);
    ifc.clr = 1'b0; ifc.wr_en = we; ifc.wr_addr = wa; ifc.wr_data = wd;
    ifc.rd_en = re; ifc.rd_addr = ra;
    if (re) qc.push_back(exp_t'{d: ec, c: cyc_n});
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst_n_c = 1'b0;
    ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = '0;
    ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = '0;
    ifc.clr = 1'b0; ifc.wr_en = 1'b0; ifc.rd_en = 1'b0;
    ifc.wr_addr = '0; ifc.wr_data = '0; ifc.rd_addr = '0;
    idle(2);

    // Reset values
    chk_ready("rst_ready", 1'b0);
    chk("rst_valid_a", 8'(ifa.rd_valid), 8'h00);
    chk("rst_valid_b", 8'(ifb.rd_valid), 8'h00);
    chk("rst_data_a", 8'(ifa.rd_data), 8'h00);
    chk("rst_data_b", 8'(ifb.rd_data), 8'h00);
    chk("rst_busy_a", 8'(ifa.busy_drop), 8'h00);

    // Init sweep with rd_en held: every request is dropped, ready after 4 edges
    ifa.rd_en = 1'b1; ifb.rd_en = 1'b1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) idle(0);
      chk_ready("init_ready", 1'(i == 4));
      chk("init_busy_a", 8'(ifa.busy_drop), 8'h01);
      chk("init_busy_b", 8'(ifb.busy_drop), 8'h01);
    end
    cyc();
    chk("init_busy_end_a", 8'(ifa.busy_drop), 8'h00);
    for (int a = 0; a < 4; a++) op(1'b0, 2'd0, 4'h0, 1'b1, 2'(a), 4'h0, 4'h0, 2'b11);
    idle(3);

    // Write then read, latency checked by scoreboard
    op(1'b1, 2'd1, 4'h9, 1'b0, 2'd0, 4'h0, 4'h0, 2'b00);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h9, 4'h9, 2'b11);
    idle(3);

    // Same-address collision: A bypasses, B returns old content
    op(1'b1, 2'd2, 4'h5, 1'b0, 2'd0, 4'h0, 4'h0, 2'b00);
    idle(1);
    op(1'b1, 2'd2, 4'hB, 1'b1, 2'd2, 4'hB, 4'h5, 2'b11);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 4'hB, 4'hB, 2'b11);
    op(1'b1, 2'd0, 4'h3, 1'b1, 2'd1, 4'h9, 4'h9, 2'b11);
    idle(3);

    // Back-to-back reads 3,2,1,0
    op(1'b1, 2'd3, 4'hC, 1'b0, 2'd0, 4'h0, 4'h0, 2'b00);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 4'hC, 4'hC, 2'b11);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 4'hB, 4'hB, 2'b11);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h9, 4'h9, 2'b11);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 4'h3, 4'h3, 2'b11);
    idle(3);
    chk("hold_data_a", 8'(ifa.rd_data), 8'h03);
    chk("hold_data_b", 8'(ifb.rd_data), 8'h03);

    // clr with reads in flight: B's read of addr 3 and both reads of addr 2 are dropped
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 4'hC, 4'hC, 2'b01);
    ifa.rd_addr = 2'd2; ifb.rd_addr = 2'd2;
    set_clr(1'b1);
    cyc();
    idle(0);
    chk_ready("clr_ready0", 1'b0);
    chk("clr_keep_a", 8'(ifa.rd_data), 8'h0C);
    chk("clr_keep_b", 8'(ifb.rd_data), 8'h03);
    cyc();
    chk_ready("clr_ready1", 1'b0);
    ifa.wr_en = 1'b1; ifa.wr_addr = 2'd1; ifa.wr_data = 4'hF;
    ifb.wr_en = 1'b1; ifb.wr_addr = 2'd1; ifb.wr_data = 4'hF;
    cyc();
    idle(0);
    chk_ready("clr_ready2", 1'b0);
    chk("sweep_drop_a", 8'(ifa.busy_drop), 8'h01);
    chk("sweep_drop_b", 8'(ifb.busy_drop), 8'h01);
    cyc();
    chk_ready("clr_ready3", 1'b0);
    chk("sweep_drop_end_a", 8'(ifa.busy_drop), 8'h00);
    cyc();
    chk_ready("clr_ready4", 1'b1);

    // clr during INIT restarts the sweep
    set_clr(1'b1);
    cyc();
    set_clr(1'b0);
    chk_ready("reinit_ready0", 1'b0);
    idle(2);
    set_clr(1'b1);
    cyc();
    set_clr(1'b0);
    chk_ready("restart_ready0", 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk_ready("restart_ready", 1'(i == 4));
    end
    for (int a = 0; a < 4; a++) op(1'b0, 2'd0, 4'h0, 1'b1, 2'(a), 4'h0, 4'h0, 2'b11);
    idle(3);

    // Async reset while rd_valid is high
    op(1'b1, 2'd1, 4'h7, 1'b0, 2'd0, 4'h0, 4'h0, 2'b00);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h7, 4'h7, 2'b01);
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h7, 4'h7, 2'b00);
    idle(0);
    chk("pre_rst_valid_a", 8'(ifa.rd_valid), 8'h01);
    chk("pre_rst_valid_b", 8'(ifb.rd_valid), 8'h01);
    chk("pre_rst_data_b", 8'(ifb.rd_data), 8'h07);
    rst_n = 1'b0;
    #1;
    chk_ready("arst_ready", 1'b0);
    chk("arst_valid_a", 8'(ifa.rd_valid), 8'h00);
    chk("arst_valid_b", 8'(ifb.rd_valid), 8'h00);
    chk("arst_data_a", 8'(ifa.rd_data), 8'h00);
    chk("arst_data_b", 8'(ifb.rd_data), 8'h00);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk_ready("arst_sweep", 1'(i == 4));
    end
    op(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h0, 4'h0, 2'b11);
    idle(3);

    // Wide configuration: 16-word sweep of A5
    ifc.rd_en = 1'b1;
    rst_n_c = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 16) ifc.rd_en = 1'b0;
      chk("c_init_ready", 8'(ifc.ready), 8'(i == 16));
      chk("c_init_busy", 8'(ifc.busy_drop), 8'h01);
    end
    cyc();
    chk("c_busy_end", 8'(ifc.busy_drop), 8'h00);
    opc(1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'hA5);
    opc(1'b1, 4'd7, 8'h3C, 1'b1, 4'd0, 8'hA5);
    opc(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h3C);
    opc(1'b1, 4'd9, 8'h5A, 1'b1, 4'd9, 8'h5A);
    opc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    cyc();
    rst_n_c = 1'b0;
    #1;
    chk("c_arst_ready", 8'(ifc.ready), 8'h00);
    chk("c_arst_data", ifc.rd_data, 8'h00);
    #1;
    rst_n_c = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("c_resweep_ready", 8'(ifc.ready), 8'(i == 16));
    end
    opc(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'hA5);
    opc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    repeat (3) cyc();

    chk("qa_drained", 8'(qa.size()), 8'h00);
    chk("qb_drained", 8'(qb.size()), 8'h00);
    chk("qc_drained", 8'(qc.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
